serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
Downstream consumer of the 8-bit serial shift register's `sout` bit stream, which arrives MSB first. It hunts for a sync byte on the stream, then deserializes a fixed-length payload plus a trailing XOR checksum byte. It presents payload bytes with a one-cycle valid strobe and reports per-frame status and good/error frame counts to the control logic.

Parameters:
WIDTH, 8, bits per byte/word; also the sync window width
SYNC, 8'hA5, sync pattern matched in the hunt window
FRAME_LEN, 4, payload bytes per frame (>=1), excluding the checksum byte

Ports:
clk  input  1  rising-edge clock
rst_p  input  1  asynchronous active-high reset
sin  input  1  serial data bit, MSB first
sin_en  input  1  bit strobe; `sin` is sampled only when high
dout  output  WIDTH  last assembled payload byte
dout_valid  output  1  one-cycle pulse when `dout` updates
sync_det  output  1  one-cycle pulse on sync match
in_frame  output  1  high while in PAYLOAD or CHECK state
frame_done  output  1  one-cycle pulse when the checksum byte completes
frame_err  output  1  valid with `frame_done`: 1 = checksum mismatch
frame_cnt  output  8  count of good frames, wraps 255->0
err_cnt  output  8  count of bad frames, saturates at 255

Behaviour:
- Reset (async, `rst_p`=1): state=HUNT; window, shift, bit_cnt, byte_cnt, chk, dout, frame_cnt and err_cnt all 0; all pulse outputs 0. Reset mid-frame discards the partial frame and counts nothing.
- All outputs are registered. Pulses last exactly one cycle. The pulse is visible the cycle after the clock edge that sampled the completing bit.
- `sin_en`=0: no shifting, no counter change, no state change. Gaps of any length between bits are legal.
- HUNT state:
  - On `sin_en`, window <= {window[WIDTH-2:0], sin}.
  - If {window[WIDTH-2:0], sin} == SYNC: sync_det=1, then go to PAYLOAD with bit_cnt=0, byte_cnt=0, chk=0.
  - The match uses the incoming bit, so no extra latency.
- PAYLOAD state:
  - On `sin_en`, shift <= {shift[WIDTH-2:0], sin}; bit_cnt++.
  - On the WIDTH-th bit: dout <= assembled byte; dout_valid=1; chk ^= byte; bit_cnt=0; byte_cnt++.
  - After byte FRAME_LEN-1 (0-based), go to CHECK.
  - SYNC patterns inside the payload are ignored.
- CHECK state:
  - Assemble WIDTH bits the same way; `dout`/`dout_valid` are NOT driven for this byte.
  - On completion: frame_done=1 and frame_err=(byte != chk).
  - Good frame: frame_cnt++, wrapping. Bad frame: err_cnt++, saturating at 255.
  - Return to HUNT with window cleared to 0, so a partial sync cannot carry over from frame bits.
- in_frame = (state != HUNT). It goes high the cycle sync_det pulses and low the cycle frame_done pulses.
- Counter widths: bit_cnt is ceil(log2(WIDTH)) bits; byte_cnt is ceil(log2(FRAME_LEN+1)) bits.
- No back-pressure: the downstream must accept `dout` on every `dout_valid`.

Test Plan:
1. Reset release, idle `sin_en`=0 for 20 cycles -> all outputs 0, in_frame=0.
2. Continuous `sin_en`, bits 0xA5 then 11 22 33 44 then checksum 0x44:
   - sync_det pulses after the 8th bit.
   - dout_valid pulses after bits 16/24/32/40 with dout=11/22/33/44.
   - frame_done=1 with frame_err=0 after bit 48; frame_cnt=1.
3. Same frame with checksum 0x45 -> frame_done=1, frame_err=1, err_cnt=1, frame_cnt unchanged. Payload containing byte A5 (A5 00 00 00, checksum A5) -> no second sync_det, frame good.
4. Alignment: stream 0xFF, 0x52, 0xD2 ... (A5 straddling a byte boundary) -> sync_det exactly on the bit completing A5; no earlier match. Junk 0x5A only -> no sync_det.
5. Random `sin_en` gaps (1-5 idle cycles) during the test 2 frame -> identical dout sequence and status. Reset asserted after the 2nd payload byte -> HUNT, counters 0. A following full frame then decodes cleanly.
6. 256 good frames back-to-back -> frame_cnt wraps to 0. 260 bad frames -> err_cnt holds at 255.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// Stream-side and status signals of serial_frame_rx, bundled for the port list.
// master = bit-stream source / status consumer, slave = the receiver.
`default_nettype none

interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             sync_det;
  logic             in_frame;
  logic             frame_done;
  logic             frame_err;
  logic [7:0]       frame_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output sin, sin_en,
    input  dout, dout_valid, sync_det, in_frame, frame_done, frame_err,
           frame_cnt, err_cnt
  );

  modport slave (
    input  sin, sin_en,
    output dout, dout_valid, sync_det, in_frame, frame_done, frame_err,
           frame_cnt, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts for a sync byte on an MSB-first bit stream, then
// deserializes a fixed-length payload followed by an XOR checksum byte.
`default_nettype none

module serial_frame_rx #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC      = 8'hA5,
  parameter int               FRAME_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_p,
  serial_frame_rx_if.slave bus
);

  localparam int BITW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BYTEW = (FRAME_LEN > 0) ? $clog2(FRAME_LEN + 1) : 1;
  localparam logic [BITW-1:0]  LAST_BIT  = BITW'(WIDTH - 1);
  localparam logic [BYTEW-1:0] LAST_BYTE = BYTEW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [BITW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTEW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WIDTH-1:0] chk_q,    chk_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sync_det_q,   sync_det_d;
  logic             in_frame_q,   in_frame_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q,  frame_err_d;
  logic [7:0]       frame_cnt_q,  frame_cnt_d;
  logic [7:0]       err_cnt_q,    err_cnt_d;

  logic [WIDTH-1:0] w_window;
  logic [WIDTH-1:0] w_shift;

  // Both candidates include the incoming bit so a match/byte completes on it.
  assign w_window = {window_q[WIDTH-2:0], bus.sin};
  assign w_shift  = {shift_q[WIDTH-2:0], bus.sin};

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    chk_d        = chk_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_det_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (bus.sin_en) begin
      case (state_q)
        HUNT: begin
          window_d = w_window;
          if (w_window == SYNC) begin
            sync_det_d = 1'b1;
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            chk_d      = '0;
          end
        end
        PAYLOAD: begin
          shift_d   = w_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            dout_d       = w_shift;
            dout_valid_d = 1'b1;
            chk_d        = chk_q ^ w_shift;
            byte_cnt_d   = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          shift_d   = w_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
            frame_err_d  = (w_shift != chk_q);
            if (w_shift == chk_q) begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d  = HUNT;
            window_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    in_frame_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= HUNT;
      window_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      chk_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_det_q   <= 1'b0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      chk_q        <= chk_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_det_q   <= sync_det_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sync_det   = sync_det_q;
  assign bus.in_frame   = in_frame_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: expected bytes and frame status are queued
// as the stream is driven and checked when the receiver pulses its outputs.
`default_nettype none

module tb_serial_frame_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] fc;
    logic [7:0] ec;
  } status_t;

  logic clk = 1'b0;
  logic rst_p;

  always #5 clk = ~clk;

  serial_frame_rx_if #(.WIDTH(8)) bus ();

  serial_frame_rx #(
    .WIDTH    (8),
    .SYNC     (8'hA5),
    .FRAME_LEN(4)
  ) dut (
    .clk  (clk),
    .rst_p(rst_p),
    .bus  (bus)
  );

  logic [7:0] dout_exp_q[$];
  status_t    stat_exp_q[$];

  int         checks = 0;
  int         failures = 0;
  int         bit_idx = 0;
  int         sync_cnt = 0;
  int         last_sync_bit = -1;
  logic [7:0] fc_m = 8'd0;
  logic [7:0] ec_m = 8'd0;
  bit         use_gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    status_t    s;
    if (bus.sync_det === 1'b1) begin
      sync_cnt++;
      last_sync_bit = bit_idx;
      check("in_frame_at_sync", {31'd0, bus.in_frame}, 32'd1);
    end
    if (bus.dout_valid === 1'b1) begin
      check("dout_expected", {31'd0, dout_exp_q.size() > 0}, 32'd1);
      if (dout_exp_q.size() > 0) begin
        e = dout_exp_q.pop_front();
        check("dout", {24'd0, bus.dout}, {24'd0, e});
      end
    end
    if (bus.frame_done === 1'b1) begin
      check("status_expected", {31'd0, stat_exp_q.size() > 0}, 32'd1);
      if (stat_exp_q.size() > 0) begin
        s = stat_exp_q.pop_front();
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, s.err});
        check("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, s.fc});
        check("err_cnt", {24'd0, bus.err_cnt}, {24'd0, s.ec});
        check("in_frame_at_done", {31'd0, bus.in_frame}, 32'd0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic send_bit(input logic b);
    if (use_gaps) begin
      repeat ($urandom_range(1, 5)) begin
        bus.sin    = 1'($urandom);
        bus.sin_en = 1'b0;
        tick();
      end
    end
    bus.sin    = b;
    bus.sin_en = 1'b1;
    tick();
    bit_idx++;
    bus.sin_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
    end
  endtask

  task automatic send_body(input logic [7:0] p[4], input logic [7:0] ck, input int s0);
    logic [7:0] x;
    status_t    s;
    x = 8'd0;
    for (int i = 0; i < 4; i++) begin
      dout_exp_q.push_back(p[i]);
      x ^= p[i];
      send_byte(p[i]);
    end
    s.err = (ck != x);
    if (ck == x) fc_m = fc_m + 8'd1;
    else if (ec_m != 8'hFF) ec_m = ec_m + 8'd1;
    s.fc = fc_m;
    s.ec = ec_m;
    stat_exp_q.push_back(s);
    send_byte(ck);
    check("dout_drained", dout_exp_q.size(), 32'd0);
    check("status_drained", stat_exp_q.size(), 32'd0);
    check("sync_once", sync_cnt, s0 + 1);
  endtask

  task automatic send_frame(input logic [7:0] p[4], input logic [7:0] ck);
    int s0;
    int b0;
    s0 = sync_cnt;
    b0 = bit_idx;
    send_byte(8'hA5);
    check("sync_pos", last_sync_bit, b0 + 7);
    send_body(p, ck, s0);
  endtask

  initial begin
    logic [7:0] f_std[4];
    logic [7:0] f_a5[4];
    int         s0;
    int         b0;

    f_std = '{8'h11, 8'h22, 8'h33, 8'h44};
    f_a5  = '{8'hA5, 8'h00, 8'h00, 8'h00};

    rst_p      = 1'b1;
    bus.sin    = 1'b0;
    bus.sin_en = 1'b0;
    repeat (3) tick();
    rst_p = 1'b0;
    repeat (20) tick();
    check("idle_dout", {24'd0, bus.dout}, 32'd0);
    check("idle_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("idle_sync_det", {31'd0, bus.sync_det}, 32'd0);
    check("idle_in_frame", {31'd0, bus.in_frame}, 32'd0);
    check("idle_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("idle_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("idle_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("idle_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    check("idle_no_sync", sync_cnt, 32'd0);

    // Good frame, bad checksum, then a payload that contains the sync byte.
    send_frame(f_std, 8'h44);
    send_frame(f_std, 8'h45);
    send_frame(f_a5, 8'hA5);
    check("cnt_after_t3_good", {24'd0, bus.frame_cnt}, 32'd2);
    check("cnt_after_t3_err", {24'd0, bus.err_cnt}, 32'd1);

    // Sync straddling a byte boundary: FF 52 then the leading 1 of D2.
    s0 = sync_cnt;
    send_byte(8'hFF);
    send_byte(8'h52);
    check("no_early_sync", sync_cnt, s0);
    b0 = bit_idx;
    send_bit(1'b1);
    check("straddle_sync_pos", last_sync_bit, b0);
    send_body(f_std, 8'h44, s0);

    s0 = sync_cnt;
    send_byte(8'h5A);
    repeat (5) tick();
    check("junk_no_sync", sync_cnt, s0);
    check("junk_in_frame", {31'd0, bus.in_frame}, 32'd0);

    // Same frame with random idle gaps between bits.
    use_gaps = 1'b1;
    send_frame(f_std, 8'h44);
    use_gaps = 1'b0;

    // Reset after the second payload byte discards the frame.
    s0 = sync_cnt;
    send_byte(8'hA5);
    dout_exp_q.push_back(8'h11);
    send_byte(8'h11);
    dout_exp_q.push_back(8'h22);
    send_byte(8'h22);
    check("pre_reset_in_frame", {31'd0, bus.in_frame}, 32'd1);
    rst_p = 1'b1;
    #1;
    check("rst_in_frame", {31'd0, bus.in_frame}, 32'd0);
    check("rst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    check("rst_dout", {24'd0, bus.dout}, 32'd0);
    check("rst_dout_drained", dout_exp_q.size(), 32'd0);
    fc_m = 8'd0;
    ec_m = 8'd0;
    repeat (2) tick();
    rst_p = 1'b0;
    tick();
    send_byte(8'h33);
    send_byte(8'h44);
    check("rst_no_resync", sync_cnt, s0 + 1);
    send_frame(f_std, 8'h44);
    check("post_reset_good", {24'd0, bus.frame_cnt}, 32'd1);

    // Counter wrap and saturation from a clean reset.
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
    fc_m = 8'd0;
    ec_m = 8'd0;
    tick();
    for (int n = 0; n < 256; n++) begin
      send_frame(f_std, 8'h44);
    end
    check("frame_cnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);
    for (int n = 0; n < 260; n++) begin
      send_frame(f_std, 8'h00);
    end
    check("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);
    check("frame_cnt_hold", {24'd0, bus.frame_cnt}, 32'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
